p_mem_ctrl: RTL and testbench
=============================

Name: p_mem_ctrl

Overview:
- Memory controller and arbiter that shares the single byte-wide RAM port between the IF stage (32-bit instruction fetch) and the MEM stage (byte/half/word load and store).
- Serialises each transaction into byte accesses and reassembles little-endian words.
- Gives MEM priority over IF and lets a branch/jump flush abort an in-flight fetch.

Parameters:
ADDR_WIDTH, 32, width of every address port and of ram_a

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous reset, active-high
rdy_in  in  1  global ready; low = pause issue
if_req  in  1  IF fetch request, held until if_done
if_addr  in  ADDR_WIDTH  fetch address
if_flush  in  1  abort pending/in-flight fetch
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched instruction
mem_req  in  1  MEM request, held until mem_done
mem_we  in  1  1 = store, 0 = load
mem_size  in  2  0 byte, 1 half, 2/3 word
mem_addr  in  ADDR_WIDTH  load/store address
mem_wdata  in  32  store data, byte 0 = bits [7:0]
mem_done  out  1  one-cycle pulse, mem_rdata valid / store committed
mem_rdata  out  32  load data, zero-extended
ram_din  in  8  RAM read data; reflects ram_a of the previous cycle
ram_dout  out  8  RAM write data
ram_a  out  ADDR_WIDTH  RAM address
ram_wr  out  1  RAM write strobe

Behaviour:
- Reset (rst_in sampled high at a rising edge): state IDLE; ram_a, ram_dout, ram_wr, if_done, if_data, mem_done, mem_rdata, byte counter and issue_valid all reset to 0. Reset overrides rdy_in and aborts any transaction mid-flight; no done pulse is produced.
- States: IDLE, RD, WR, DONE. Owner register: IF or MEM.
- IDLE, on an edge with rdy_in high:
  - mem_req wins: RD if mem_we=0, WR if mem_we=1.
  - Otherwise if_req and not if_flush: RD, owner IF.
  - Otherwise stay in IDLE.
- On acceptance:
  - Latch base address, N and wdata; clear the byte counter k and the read lanes.
  - N = 1/2/4 for mem_size 0/1/≥2; IF is always N=4.
- RD:
  - In cycle k (0 ≤ k < N) with rdy_in high: drive ram_a = base+k, ram_wr=0, set issue_valid, k advances.
  - Every edge where issue_valid is set: capture ram_din into lane (last issued index). Capture happens regardless of rdy_in.
  - After byte N-1 is captured: go to DONE.
  - Word read: accept at edge E; done is high in the cycle after edge E+5.
- WR:
  - Cycle k with rdy_in high: ram_a = base+k, ram_dout = wdata byte k, ram_wr=1, k advances.
  - After byte N-1: go to DONE.
  - Word write: done is high in the cycle after edge E+4.
- DONE: owner's done = 1 for exactly one cycle, with its data stable; the next state is IDLE unconditionally. The requester drops req on that edge, so no transaction is serviced twice.
- rdy_in low:
  - No new address is issued; ram_wr=0; state and k hold; ram_a and ram_dout hold their values.
  - issue_valid clears after the capture of the byte issued in the previous cycle, so no byte is ever captured twice.
- Address arithmetic: base+k is modulo 2^ADDR_WIDTH and wraps past 0xFFFFFFFF. Misaligned addresses are legal.
- mem_rdata: lanes above N-1 read as 0. Sign extension is not this block's job.
- if_flush:
  - During an IF RD: go to IDLE at that edge, discard the in-flight byte, no if_done.
  - During an IF DONE: no effect; if_done still pulses.
  - During MEM transactions: ignored.
- Requests are never preempted. A mem_req arriving mid-fetch waits for the fetch to reach DONE, then IDLE.
- if_data and mem_rdata hold their last value until the next capture for the same owner begins.

Test Plan:
1. RAM[0x100..0x103] = 13 05 10 00; if_req, if_addr=0x100 -> ram_a steps 0x100..0x103; if_done pulses once with if_data=0x00100513 in the cycle after edge E+5.
2. mem_req, mem_we=1, mem_size=1, mem_addr=0x20, mem_wdata=0xAABBCCDD -> ram_wr=1 for two cycles writing DD@0x20 and CC@0x21; mem_done pulses after edge E+2; RAM[0x22] unchanged.
3. if_req and mem_req (load byte 0x30, RAM=0x85) raised in the same cycle -> MEM served first with mem_rdata=0x00000085; IF fetch starts one cycle after mem_done.
4. if_flush in RD cycle 2 of a fetch at 0x200 -> no if_done; IDLE next cycle; a new if_req at 0x300 is then fetched correctly.
5. rdy_in low for 3 cycles mid word load at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 0, 1 with no byte lost or duplicated; mem_rdata correct; done delayed by exactly 3 cycles.
6. rst_in high mid word store, after byte 1 -> next cycle ram_wr=0, no mem_done, all outputs 0, state IDLE.

Source files
------------

// File: rtl/p_mem_ctrl.sv
// rtl/p_mem_ctrl.sv - byte-serial RAM arbiter/controller shared by IF fetch and MEM load/store
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                global ready; low pauses address issue
//   if_req/if_addr        32-bit instruction fetch request (held until if_done)
//   if_flush              aborts a pending or in-flight fetch
//   if_done/if_data       one-cycle completion pulse and fetched word
//   mem_req/mem_we        load/store request (held until mem_done), 1 = store
//   mem_size/mem_addr     0 byte, 1 half, 2/3 word; byte address
//   mem_wdata             store data, byte 0 in bits [7:0]
//   mem_done/mem_rdata    one-cycle completion pulse and zero-extended load data
//   ram_din               RAM read data for the address driven in the previous cycle
//   ram_dout/ram_a/ram_wr RAM write data, address and write strobe
module p_mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  state_t                state, state_nxt;
  logic                  owner_mem;     // 1 = MEM owns the current transaction, 0 = IF
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            len;           // bytes in the transaction: 1, 2 or 4
  logic [2:0]            k;             // next byte index to issue
  logic [2:0]            k_prev;
  logic [2:0]            mem_len;
  logic [31:0]           wdata;
  logic [31:0]           wdata_sh;
  logic [31:0]           lanes;         // read bytes gathered so far
  logic [31:0]           lanes_cap;     // lanes with the byte arriving this cycle merged in
  logic                  issue_valid;   // a read address was driven last cycle; its data is on ram_din
  logic                  accept_mem, accept_if, flush_rd, issue, last_cap, done_set;
  logic [ADDR_WIDTH-1:0] ram_a_nxt;
  logic [7:0]            ram_dout_nxt;
  logic                  ram_wr_nxt;

  assign accept_mem = (state == IDLE) && rdy_in && mem_req;
  assign accept_if  = (state == IDLE) && rdy_in && !mem_req && if_req && !if_flush;
  assign flush_rd   = (state == RD) && !owner_mem && if_flush;
  assign issue      = rdy_in && (k < len) && ((state == WR) || ((state == RD) && !flush_rd));
  // The byte in flight belongs to index k-1; when k has reached len it is the last one.
  assign last_cap   = (state == RD) && issue_valid && (k == len);
  assign done_set   = (state != DONE) && (state_nxt == DONE);
  assign k_prev     = k - 3'd1;
  assign wdata_sh   = wdata >> {k[1:0], 3'b000};

  always_comb begin
    mem_len = 3'd4;
    if (mem_size == 2'd0)      mem_len = 3'd1;
    else if (mem_size == 2'd1) mem_len = 3'd2;
  end

  always_comb begin
    lanes_cap = lanes;
    lanes_cap[{k_prev[1:0], 3'b000} +: 8] = ram_din;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_mem)     state_nxt = mem_we ? WR : RD;
        else if (accept_if) state_nxt = RD;
      end
      RD: begin
        if (flush_rd)      state_nxt = IDLE;
        else if (last_cap) state_nxt = DONE;
      end
      WR: begin
        if (issue && (k == len - 3'd1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port outputs; address and data hold whenever nothing is issued
  always_comb begin
    ram_a_nxt    = ram_a;
    ram_dout_nxt = ram_dout;
    ram_wr_nxt   = 1'b0;
    if (issue) begin
      ram_a_nxt = base + ADDR_WIDTH'(k);
      if (state == WR) begin
        ram_dout_nxt = wdata_sh[7:0];
        ram_wr_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ram_a       <= '0;
      ram_dout    <= '0;
      ram_wr      <= 1'b0;
      if_done     <= 1'b0;
      if_data     <= '0;
      mem_done    <= 1'b0;
      mem_rdata   <= '0;
      k           <= '0;
      issue_valid <= 1'b0;
      owner_mem   <= 1'b0;
      base        <= '0;
      len         <= '0;
      wdata       <= '0;
      lanes       <= '0;
    end else begin
      ram_a    <= ram_a_nxt;
      ram_dout <= ram_dout_nxt;
      ram_wr   <= ram_wr_nxt;
      if_done  <= done_set && !owner_mem;
      mem_done <= done_set && owner_mem;
      if (accept_mem || accept_if) begin
        owner_mem   <= accept_mem;
        base        <= accept_mem ? mem_addr : if_addr;
        len         <= accept_mem ? mem_len : 3'd4;
        wdata       <= mem_wdata;
        k           <= '0;
        lanes       <= '0;
        issue_valid <= 1'b0;
      end else begin
        if (issue) k <= k + 3'd1;
        // Cleared on a stall so the byte already captured is not taken again.
        issue_valid <= issue && (state == RD);
        if (issue_valid) lanes <= lanes_cap;
        if (done_set && (state == RD)) begin
          if (owner_mem) mem_rdata <= lanes_cap;
          else           if_data   <= lanes_cap;
        end
      end
    end
  end

endmodule

// File: tb/tb_p_mem_ctrl.sv
// tb/tb_p_mem_ctrl.sv - scoreboard testbench for p_mem_ctrl
module tb_p_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  logic        fixed_rdy;
  logic        rand_rdy;
  logic        rnd_rdy = 1'b1;
  assign rdy_in = rand_rdy ? rnd_rdy : fixed_rdy;

  p_mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) rnd_rdy <= ($urandom_range(0, 3) != 0);

  // RAM aliased onto 4 KiB; the model uses the same folding.
  logic [7:0]  ram_arr   [4096];
  logic [7:0]  model_mem [4096];
  assign ram_din = ram_arr[ram_a[11:0]];

  logic [31:0] mem_q[$];
  logic [31:0] if_q[$];
  logic [31:0] trace_q[$];
  logic [31:0] last_mem_val, last_if_val;
  int          checks = 0, errors = 0;
  int          n_mem_done = 0, n_if_done = 0;
  int          wr_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a = addr + 32'(i);
      v = v | (32'(model_mem[a[11:0]]) << (8 * i));
    end
    return v;
  endfunction

  task monitor();
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        if (mem_done) begin
          n_mem_done++;
          if (mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_done_unexpected: got pulse at cycle %0d required none", cyc);
          end else chk("mem_rdata", mem_rdata, mem_q.pop_front());
        end
        if (if_done) begin
          n_if_done++;
          if (if_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL if_done_unexpected: got pulse at cycle %0d required none", cyc);
          end else chk("if_data", if_data, if_q.pop_front());
        end
      end
    end
  endtask

  task ram_proc();
    forever begin
      @(posedge clk_in);
      if (ram_wr) ram_arr[ram_a[11:0]] <= ram_dout;
    end
  endtask

  task automatic run_mem(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall_at, input int stall_len,
                         output int lat);
    int n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    int m, start;
    @(negedge clk_in); #1;
    if (!we) begin
      last_mem_val = model_load(addr, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        logic [31:0] a = addr + 32'(i);
        model_mem[a[11:0]] = wdata[8*i +: 8];
      end
    end
    mem_q.push_back(last_mem_val);
    mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    m = cyc; start = n_mem_done; lat = -1; wr_cnt = 0; trace_q.delete();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_in); #1;
      if (stall_len > 0 && cyc == m + 1 + stall_at) fixed_rdy = 1'b0;
      if (stall_len > 0 && cyc == m + 1 + stall_at + stall_len) fixed_rdy = 1'b1;
      if (cyc >= m + 2) begin
        if (trace_q.size() == 0 || trace_q[$] != ram_a) trace_q.push_back(ram_a);
        if (ram_wr) wr_cnt++;
      end
      if (n_mem_done != start) begin lat = cyc - m; break; end
    end
    mem_req = 1'b0;
    fixed_rdy = 1'b1;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL mem_timeout: got no mem_done required one (addr %h)", addr);
    end
    if (we) begin
      @(negedge clk_in); #1;
      chk("ram_wr_after_store", 32'(ram_wr), 32'd0);
      for (int i = 0; i <= n; i++) begin
        logic [31:0] a = addr + 32'(i);
        chk("ram_contents", 32'(ram_arr[a[11:0]]), 32'(model_mem[a[11:0]]));
      end
    end
  endtask

  task automatic run_if(input logic [31:0] addr, input int flush_at, output int lat);
    int m, start;
    @(negedge clk_in); #1;
    if (flush_at < 0) begin
      last_if_val = model_load(addr, 4);
      if_q.push_back(last_if_val);
    end
    if_req = 1'b1; if_addr = addr;
    m = cyc; start = n_if_done; lat = -1; trace_q.delete();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_in); #1;
      if (cyc >= m + 2 && (trace_q.size() == 0 || trace_q[$] != ram_a)) trace_q.push_back(ram_a);
      if (flush_at >= 0 && cyc == m + 1 + flush_at) begin
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk_in); #1;
        if_flush = 1'b0;
        repeat (8) @(negedge clk_in);
        #1;
        chk("flush_no_if_done", 32'(n_if_done - start), 32'd0);
        break;
      end
      if (n_if_done != start) begin lat = cyc - m; break; end
    end
    if_req = 1'b0;
    if (flush_at < 0 && lat < 0) begin
      checks++; errors++;
      $display("FAIL if_timeout: got no if_done required one (addr %h)", addr);
    end
  endtask

  task automatic check_trace(input string nm, input logic [31:0] start, input int n);
    chk(nm, 32'(trace_q.size()), 32'(n));
    for (int i = 0; i < n && i < trace_q.size(); i++) chk(nm, trace_q[i], start + 32'(i));
  endtask

  task automatic main_seq();
    int lat, li, lm, m, sm, si;
    logic [7:0] saved;
    // reset state
    @(negedge clk_in); #1;
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);

    // 1: word fetch
    run_if(32'h100, -1, lat);
    chk("t1_lat", 32'(lat), 32'd6);
    chk("t1_if_data", if_data, 32'h00100513);
    check_trace("t1_trace", 32'h100, 4);

    // 2: half store
    saved = ram_arr[12'h22];
    run_mem(1'b1, 2'd1, 32'h20, 32'hAABBCCDD, 0, 0, lat);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_wr_cycles", 32'(wr_cnt), 32'd2);
    check_trace("t2_trace", 32'h20, 2);
    chk("t2_byte20", 32'(ram_arr[12'h20]), 32'hDD);
    chk("t2_byte21", 32'(ram_arr[12'h21]), 32'hCC);
    chk("t2_byte22", 32'(ram_arr[12'h22]), 32'(saved));

    // 3: simultaneous requests, MEM first
    @(negedge clk_in); #1;
    last_mem_val = model_load(32'h30, 1);
    mem_q.push_back(last_mem_val);
    last_if_val = model_load(32'h140, 4);
    if_q.push_back(last_if_val);
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h30;
    if_req = 1'b1; if_addr = 32'h140;
    m = cyc; sm = n_mem_done; si = n_if_done; lm = -1; li = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk_in); #1;
      if (lm < 0 && n_mem_done != sm) begin lm = cyc - m; mem_req = 1'b0; end
      if (n_if_done != si) begin li = cyc - m; break; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("t3_mem_lat", 32'(lm), 32'd3);
    chk("t3_if_lat", 32'(li), 32'd10);
    chk("t3_mem_rdata", mem_rdata, 32'h00000085);

    // 4: flush mid-fetch, then a clean fetch
    run_if(32'h200, 2, lat);
    chk("t4_if_data_hold", if_data, last_if_val);
    run_if(32'h300, -1, lat);
    chk("t4_refetch_lat", 32'(lat), 32'd6);

    // 5: stalled wrapping word load
    run_mem(1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, 1, 3, lat);
    chk("t5_lat", 32'(lat), 32'd9);
    check_trace("t5_trace", 32'hFFFFFFFE, 4);
    chk("t5_rdata", mem_rdata, model_load(32'hFFFFFFFE, 4));

    // 6: reset in the middle of a word store
    @(negedge clk_in); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h50; mem_wdata = 32'h11223344;
    m = cyc;
    while (cyc < m + 3) begin @(negedge clk_in); #1; end
    rst_in = 1'b1; mem_req = 1'b0;
    @(negedge clk_in); #1;
    rst_in = 1'b0;
    chk("t6_ram_wr", 32'(ram_wr), 32'd0);
    chk("t6_ram_a", ram_a, 32'd0);
    chk("t6_outputs", {if_data | mem_rdata}, 32'd0);
    chk("t6_dones", {30'd0, if_done, mem_done}, 32'd0);
    model_mem[12'h50] = 8'h44;
    model_mem[12'h51] = 8'h33;
    last_mem_val = '0; last_if_val = '0;
    chk("t6_byte52", 32'(ram_arr[12'h52]), 32'(model_mem[12'h52]));
    repeat (4) @(negedge clk_in);
    run_mem(1'b0, 2'd2, 32'h50, 32'h0, 0, 0, lat);
    chk("t6_after_lat", 32'(lat), 32'd6);

    // randomized traffic under random rdy_in
    rand_rdy = 1'b1;
    for (int it = 0; it < 80; it++) begin
      logic [31:0] addr = 32'($urandom_range(0, 63)) + (($urandom_range(0, 1) == 1) ? 32'h400 : 32'hFFFFFFE0);
      int kind = $urandom_range(0, 2);
      if (kind == 0)      run_if(addr, -1, lat);
      else if (kind == 1) run_mem(1'b0, 2'($urandom_range(0, 3)), addr, 32'h0, 0, 0, lat);
      else                run_mem(1'b1, 2'($urandom_range(0, 3)), addr, $urandom, 0, 0, lat);
    end
    rand_rdy = 1'b0;
    repeat (4) @(negedge clk_in);
    #1;
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; fixed_rdy = 1'b1; rand_rdy = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
    last_mem_val = '0; last_if_val = '0; wr_cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      ram_arr[i] = 8'($urandom);
      model_mem[i] = ram_arr[i];
    end
    ram_arr[12'h100] = 8'h13; ram_arr[12'h101] = 8'h05; ram_arr[12'h102] = 8'h10; ram_arr[12'h103] = 8'h00;
    ram_arr[12'h30] = 8'h85;
    for (int i = 0; i < 4096; i++) model_mem[i] = ram_arr[i];
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    fork
      monitor();
      ram_proc();
      main_seq();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
